factorial_engine: RTL and testbench

//  Parametrised iterative factorial unit with its own controller FSM and start/done handshake.

---
 rtl/fact_pkg.sv | 12 +
 rtl/fact_mul_unit.sv | 22 ++
 rtl/factorial_engine.sv | 103 ++++++++++
 tb/tb_factorial_engine.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fact_pkg.sv
// Shared types and constants for the iterative factorial engine.
package fact_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } fact_state_e;

  localparam int FACT_ACC_INIT = 1;

endpackage

// File: rtl/fact_mul_unit.sv
// Combinational acc*cnt multiplier with upper-half overflow detect.
module fact_mul_unit
  import fact_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NBITS_N = 6
) (
  input  logic [WIDTH-1:0]   acc,
  input  logic [NBITS_N-1:0] cnt,
  output logic [WIDTH-1:0]   prod_lo,
  output logic               ovf
);

  logic [WIDTH-1:0]   cnt_ext;
  logic [2*WIDTH-1:0] prod;

  assign cnt_ext = WIDTH'(cnt);
  assign prod    = (2*WIDTH)'(acc) * (2*WIDTH)'(cnt_ext);
  assign prod_lo = prod[WIDTH-1:0];
  assign ovf     = |prod[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/factorial_engine.sv
// Iterative n! engine with start/done handshake and overflow flag.
// Define FACT_SATURATE_EN to saturate the result instead of wrapping.
module factorial_engine
  import fact_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NBITS_N = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [NBITS_N-1:0] n_in,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic               overflow
);

  fact_state_e state, next;

  logic [WIDTH-1:0]   acc;
  logic [NBITS_N-1:0] cnt;
  logic [WIDTH-1:0]   prod_lo;
  logic               ovf;
  logic               accept;
  logic               step;
  logic               finish;

  fact_mul_unit #(
    .WIDTH  (WIDTH),
    .NBITS_N(NBITS_N)
  ) u_mul (
    .acc    (acc),
    .cnt    (cnt),
    .prod_lo(prod_lo),
    .ovf    (ovf)
  );

  always_comb begin
    next   = state;
    accept = 1'b0;
    step   = 1'b0;
    finish = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
          next   = CALC;
        end
      end
      CALC: begin
        if (cnt <= NBITS_N'(1)) begin
          finish = 1'b1;
          next   = DONE;
        end else begin
          step = 1'b1;
        end
      end
      DONE: next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= next;
      busy  <= (next == CALC);
      done  <= (next == DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= WIDTH'(FACT_ACC_INIT);
      cnt      <= '0;
      result   <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        acc      <= WIDTH'(FACT_ACC_INIT);
        cnt      <= n_in;
        overflow <= 1'b0;
      end
      if (step) begin
        cnt <= cnt - NBITS_N'(1);
        if (ovf) overflow <= 1'b1;
`ifdef FACT_SATURATE_EN
        // Once saturated, hold all-ones; cnt keeps counting for fixed latency.
        if (overflow || ovf) acc <= '1;
        else                 acc <= prod_lo;
`else
        acc <= prod_lo;
`endif
      end
      if (finish) result <= acc;
    end
  end

endmodule

// File: tb/tb_factorial_engine.sv
// Directed self-checking bench for factorial_engine.
module tb_factorial_engine;

  logic        clk;
  logic        rst;
  logic        start;
  logic [5:0]  n_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        overflow;

  int total;
  int bad;

  factorial_engine #(
    .WIDTH  (32),
    .NBITS_N(6)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .n_in    (n_in),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic run_op(input int n, output int lat, output int bcnt);
    @(negedge clk);
    start = 1'b1;
    n_in  = 6'(n);
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 0;
    bcnt  = 0;
    while (!done && lat < 200) begin
      if (busy) bcnt++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    n_in  = '0;
    repeat (2) @(posedge clk);
    #1;
    total += 4;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL rst_busy got=%b want=0", busy);
    end
    if (done !== 1'b0) begin
      bad++; $display("FAIL rst_done got=%b want=0", done);
    end
    if (result !== 32'd0) begin
      bad++; $display("FAIL rst_result got=%0d want=0", result);
    end
    if (overflow !== 1'b0) begin
      bad++; $display("FAIL rst_ovf got=%b want=0", overflow);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_op(input string nm, input int n, input logic [31:0] er,
                         input logic eo, input int elat, input int ebusy);
    int lat, bc;
    run_op(n, lat, bc);
    total += 4;
    if (lat !== elat) begin
      bad++; $display("FAIL %s_latency got=%0d want=%0d", nm, lat, elat);
    end
    if (result !== er) begin
      bad++; $display("FAIL %s_result got=%0d want=%0d", nm, result, er);
    end
    if (overflow !== eo) begin
      bad++; $display("FAIL %s_ovf got=%b want=%b", nm, overflow, eo);
    end
    if (bc !== ebusy) begin
      bad++; $display("FAIL %s_busy_cycles got=%0d want=%0d", nm, bc, ebusy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_ignore_start();
    int lat;
    @(negedge clk);
    start = 1'b1;
    n_in  = 6'd10;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      lat++;
    end
    @(negedge clk);
    start = 1'b1;
    n_in  = 6'd4;
    @(posedge clk);
    #1;
    lat++;
    start = 1'b0;
    while (!done && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    total += 3;
    if (lat !== 10) begin
      bad++; $display("FAIL ign_latency got=%0d want=10", lat);
    end
    if (result !== 32'd3628800) begin
      bad++; $display("FAIL ign_result got=%0d want=3628800", result);
    end
    @(posedge clk);
    #1;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL ign_requeued busy=%b want=0", busy);
    end
  endtask

  task automatic test_abort();
    @(negedge clk);
    start = 1'b1;
    n_in  = 6'd10;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total += 4;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL abort_busy got=%b want=0", busy);
    end
    if (done !== 1'b0) begin
      bad++; $display("FAIL abort_done got=%b want=0", done);
    end
    if (result !== 32'd0) begin
      bad++; $display("FAIL abort_result got=%0d want=0", result);
    end
    if (overflow !== 1'b0) begin
      bad++; $display("FAIL abort_ovf got=%b want=0", overflow);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    start = 1'b1;
    n_in  = 6'd2;
    @(posedge clk);
    #1;
    lat = 0;
    while (!done && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    @(posedge clk);
    #1;
    total += 3;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL b2b_idle busy=%b done=%b want=0/0", busy, done);
    end
    @(posedge clk);
    #1;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL b2b_reaccept busy=%b want=1", busy);
    end
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    while (!done && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (result !== 32'd2) begin
      bad++; $display("FAIL b2b_result got=%0d want=2", result);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_op("n5", 5, 32'd120, 1'b0, 5, 5);
    test_op("n0", 0, 32'd1, 1'b0, 1, 1);
    test_op("n1", 1, 32'd1, 1'b0, 1, 1);
    test_op("n12", 12, 32'd479001600, 1'b0, 12, 12);
`ifdef FACT_SATURATE_EN
    test_op("n13", 13, 32'hFFFFFFFF, 1'b1, 13, 13);
`else
    test_op("n13", 13, 32'd1932053504, 1'b1, 13, 13);
`endif
    test_op("n6", 6, 32'd720, 1'b0, 6, 6);
    test_ignore_start();
    test_abort();
    test_op("n3", 3, 32'd6, 1'b0, 3, 3);
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
